sipo_rx: RTL and testbench
==========================

Name: sipo_rx

Overview:
Serial-in parallel-out receiver. It is the receive end of the team's PISO serial link. It assembles N serial bits, sampled on a per-bit strobe, into a parallel word. Bit order is selectable: MSB-first or LSB-first. The completed word is presented on a valid/ready output register, and a word that cannot be accepted is flagged as overrun.

Parameters:
N, 4, data word width in bits; legal range N >= 2.

Ports:
clk  input  1  clock; all logic on the rising edge.
rst  input  1  reset; asynchronous, active-high.
direction  input  1  bit order. 1 = MSB-first (first bit received lands in dout[N-1]). 0 = LSB-first (first bit lands in dout[0]).
din_valid  input  1  strobe; din is sampled on an edge where din_valid=1.
din  input  1  serial data bit.
clear  input  1  synchronous frame abort.
dout  output  N  assembled parallel word (output register).
dout_valid  output  1  dout holds an unconsumed word.
dout_ready  input  1  consumer accepts dout when dout_valid && dout_ready.
busy  output  1  a frame is partially received (bit_cnt != 0).
bit_cnt  output  clog2(N+1)  bits received in the current frame.
overrun  output  1  sticky; a completed word was dropped.
parity_err  output  1  parity status of dout (see Optional Feature).

Behaviour:
- Reset values (async): dout=0, dout_valid=0, busy=0, bit_cnt=0, overrun=0, parity_err=0.
- Reset also clears the internal shift register, the latched direction and the state.
- States:
  - IDLE (bit_cnt=0).
  - SHIFT (0 < bit_cnt < N).
  - PARITY (only with the optional feature).
  - Transitions: IDLE->SHIFT on the first sampled bit. SHIFT->IDLE on the edge that samples the final bit of the frame.
- Direction latching:
  - direction is latched on the first bit of a frame (the IDLE sample).
  - That latched value governs the entire frame; changes mid-frame are ignored.
- Shifting:
  - MSB-first: sreg <= {sreg[N-2:0], din}.
  - LSB-first: sreg <= {din, sreg[N-1:1]}.
  - Cycles with din_valid=0 hold all state; gaps between bits are unlimited.
- Completion: on the edge that samples bit N, the assembled word (including that bit) is written to dout, dout_valid is set, and bit_cnt returns to 0.
  - Latency: dout_valid is high in the cycle immediately after the final-bit edge.
- Handshake:
  - dout and dout_valid hold until an edge with dout_valid && dout_ready.
  - After that edge, dout_valid=0 unless a new word completes on the same edge.
  - dout keeps its last value after consumption.
- Simultaneous completion and consumption: the new word is loaded and dout_valid stays 1. There is no bubble and no overrun.
- Overrun:
  - Condition: a completion occurs while dout_valid=1 and dout_ready=0.
  - Result: the new word is discarded, dout is unchanged, and overrun is set to 1.
  - overrun is cleared only by rst or clear.
- clear (synchronous):
  - Discards the partial frame: bit_cnt=0, sreg=0, state IDLE. Clears overrun.
  - Does not affect dout, dout_valid or parity_err.
  - Has priority over din_valid in the same cycle; that bit is lost.
- No mid-frame data is ever visible on dout.

Optional Feature:
PARITY_CHECK_EN
- Defined:
  - A frame is N data bits followed by one even-parity bit (state PARITY after bit N). bit_cnt counts to N+1.
  - Completion occurs on the parity-bit edge. Latency is therefore one bit longer.
  - parity_err is loaded together with dout: 1 when XOR(data bits, parity bit) != 0.
  - The word is delivered even on a parity error.
  - Overrun and clear rules apply to the whole N+1-bit frame.
- Not defined: frames are N bits, there is no PARITY state, and parity_err is tied to 0.

Test Plan:
1. N=4, direction=1, din_valid on 4 consecutive cycles, bits 1,0,1,1 -> dout=4'b1011 and dout_valid=1 one cycle after the 4th bit; busy=1 during bits 2-4.
2. direction=0, bits 1,1,0,1 with 2-cycle gaps (din_valid=0) -> dout=4'b1011. Toggling direction after bit 1 does not change the result.
3. dout_ready=0, two back-to-back frames 4'b0011 then 4'b1100 -> dout stays 4'b0011 and overrun=1. Then clear=1 -> overrun=0, dout still 4'b0011, dout_valid still 1.
4. dout_ready=1, frame 2 completes on the same edge that frame 1 is consumed -> dout switches to the new word, dout_valid stays 1, overrun=0.
5. Assert rst asynchronously after 2 bits -> all outputs 0 immediately. The next 4 bits 0,1,1,0 (MSB-first) yield 4'b0110 with no residue.
6. PARITY_CHECK_EN: MSB-first, data 1,0,1,1 + parity 1 -> dout=4'b1011, parity_err=0. Same data with parity 0 -> parity_err=1.

Source files
------------

// File: rtl/sipo_rx.sv
// Serial-in parallel-out receiver: assembles N strobed serial bits into a word
// delivered on a valid/ready output register. Optional macro: PARITY_CHECK_EN.
module sipo_rx #(
    parameter int N = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   direction,
    input  logic                   din_valid,
    input  logic                   din,
    input  logic                   clear,
    output logic [N-1:0]           dout,
    output logic                   dout_valid,
    input  logic                   dout_ready,
    output logic                   busy,
    output logic [$clog2(N+1)-1:0] bit_cnt,
    output logic                   overrun,
    output logic                   parity_err
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST_DATA = CW'(N - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SHIFT  = 2'd1;
`ifdef PARITY_CHECK_EN
    localparam logic [1:0] S_PARITY = 2'd2;
`endif

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] bit_cnt_q, bit_cnt_d;
    logic [N-1:0]  sreg_q, sreg_d;
    logic          dir_q, dir_d;
    logic [N-1:0]  dout_q, dout_d;
    logic          dout_valid_q, dout_valid_d;
    logic          overrun_q, overrun_d;
    logic          parity_err_q, parity_err_d;

    logic          dir_eff;
    logic [N-1:0]  shifted;
    logic          complete;
    logic [N-1:0]  word;
    logic          word_perr;

    // The first bit of a frame uses the live direction; later bits use the latched one.
    assign dir_eff = (state_q == S_IDLE) ? direction : dir_q;
    assign shifted = dir_eff ? {sreg_q[N-2:0], din} : {din, sreg_q[N-1:1]};

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        sreg_d    = sreg_q;
        dir_d     = dir_q;
        complete  = 1'b0;
        word      = sreg_q;
        word_perr = 1'b0;

        if (clear) begin
            state_d   = S_IDLE;
            bit_cnt_d = '0;
            sreg_d    = '0;
        end else if (din_valid) begin
            case (state_q)
                S_IDLE: begin
                    dir_d     = direction;
                    sreg_d    = shifted;
                    bit_cnt_d = CW'(1);
                    state_d   = S_SHIFT;
                end
                S_SHIFT: begin
                    if (bit_cnt_q == LAST_DATA) begin
`ifdef PARITY_CHECK_EN
                        sreg_d    = shifted;
                        bit_cnt_d = bit_cnt_q + CW'(1);
                        state_d   = S_PARITY;
`else
                        complete  = 1'b1;
                        word      = shifted;
                        sreg_d    = '0;
                        bit_cnt_d = '0;
                        state_d   = S_IDLE;
`endif
                    end else begin
                        sreg_d    = shifted;
                        bit_cnt_d = bit_cnt_q + CW'(1);
                    end
                end
`ifdef PARITY_CHECK_EN
                S_PARITY: begin
                    // Even parity: data bits XOR parity bit must be zero.
                    complete  = 1'b1;
                    word      = sreg_q;
                    word_perr = ^{sreg_q, din};
                    sreg_d    = '0;
                    bit_cnt_d = '0;
                    state_d   = S_IDLE;
                end
`endif
                default: begin
                    state_d   = S_IDLE;
                    bit_cnt_d = '0;
                    sreg_d    = '0;
                end
            endcase
        end
    end

    always_comb begin
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        overrun_d    = overrun_q;
        parity_err_d = parity_err_q;

        if (clear) begin
            overrun_d = 1'b0;
        end

        // A completed word finding the register full and not being drained is dropped.
        if (complete && dout_valid_q && !dout_ready) begin
            overrun_d = 1'b1;
        end else begin
            if (dout_valid_q && dout_ready) begin
                dout_valid_d = 1'b0;
            end
            if (complete) begin
                dout_d       = word;
                dout_valid_d = 1'b1;
                parity_err_d = word_perr;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            bit_cnt_q    <= '0;
            sreg_q       <= '0;
            dir_q        <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            sreg_q       <= sreg_d;
            dir_q        <= dir_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            overrun_q    <= overrun_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign busy       = (bit_cnt_q != '0);
    assign bit_cnt    = bit_cnt_q;
    assign overrun    = overrun_q;
    assign parity_err = parity_err_q;

endmodule

// File: tb/tb_sipo_rx.sv
// Directed bench for sipo_rx (N=4); parity cases run when PARITY_CHECK_EN is defined.
module tb_sipo_rx;

    localparam int N = 4;
`ifdef PARITY_CHECK_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic         direction;
    logic         din_valid;
    logic         din;
    logic         clear;
    logic [N-1:0] dout;
    logic         dout_valid;
    logic         dout_ready;
    logic         busy;
    logic [2:0]   bit_cnt;
    logic         overrun;
    logic         parity_err;

    int checks = 0;
    int errors = 0;

    sipo_rx #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .direction  (direction),
        .din_valid  (din_valid),
        .din        (din),
        .clear      (clear),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy),
        .bit_cnt    (bit_cnt),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock with the given strobe/bit; returns 1 time unit after the edge.
    task automatic step(input logic v, input logic b);
        din_valid = v;
        din       = b;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        din       = 1'b0;
    endtask

    task automatic par_bit(input logic p);
        if (PAR) step(1'b1, p);
    endtask

    task automatic send4(input logic [3:0] bits_in_order);
        for (int i = 3; i >= 0; i--) step(1'b1, bits_in_order[i]);
        par_bit(^bits_in_order);
    endtask

    task automatic consume();
        dout_ready = 1'b1;
        step(1'b0, 1'b0);
        dout_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        clk = 0; rst = 1; direction = 1; din_valid = 0; din = 0;
        clear = 0; dout_ready = 0;
        #3;
        check("rst_dout", dout, 0);
        check("rst_valid", dout_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_cnt", bit_cnt, 0);
        check("rst_ovr", overrun, 0);
        check("rst_perr", parity_err, 0);
        @(posedge clk); #1;
        rst = 0;

        // Test 1: MSB-first, back-to-back bits 1,0,1,1
        direction = 1;
        step(1, 1);
        check("t1_cnt1", bit_cnt, 1);
        check("t1_busy1", busy, 1);
        step(1, 0);
        check("t1_cnt2", bit_cnt, 2);
        step(1, 1);
        check("t1_cnt3", bit_cnt, 3);
        check("t1_valid_pre", dout_valid, 0);
        step(1, 1);
        par_bit(1'b1);
        check("t1_dout", dout, 4'b1011);
        check("t1_valid", dout_valid, 1);
        check("t1_busy_end", busy, 0);
        check("t1_cnt_end", bit_cnt, 0);
        consume();
        check("t1_consumed", dout_valid, 0);
        check("t1_dout_kept", dout, 4'b1011);

        // Test 2: LSB-first with gaps; direction flips after bit 1
        direction = 0;
        step(1, 1);
        direction = 1;
        step(0, 0); step(0, 0);
        check("t2_gap_cnt", bit_cnt, 1);
        step(1, 1);
        step(0, 0); step(0, 0);
        step(1, 0);
        step(0, 0); step(0, 0);
        step(1, 1);
        par_bit(1'b1);
        check("t2_dout", dout, 4'b1011);
        check("t2_valid", dout_valid, 1);
        consume();

        // Test 3: overrun then clear (with a dropped strobe)
        direction = 1;
        send4(4'b0011);
        send4(4'b1100);
        check("t3_dout", dout, 4'b0011);
        check("t3_ovr", overrun, 1);
        check("t3_valid", dout_valid, 1);
        step(1, 1); step(1, 0);
        check("t3_partial", bit_cnt, 2);
        clear = 1;
        step(1, 1);
        clear = 0;
        check("t3_clr_ovr", overrun, 0);
        check("t3_clr_cnt", bit_cnt, 0);
        check("t3_clr_busy", busy, 0);
        check("t3_clr_dout", dout, 4'b0011);
        check("t3_clr_valid", dout_valid, 1);
        consume();

        // Test 4: completion on the same edge as consumption
        send4(4'b1001);
        check("t4_first", dout, 4'b1001);
        for (int i = 3; i >= 1; i--) step(1, 1'(4'b0110 >> i));
        if (PAR) step(1, 0);
        dout_ready = 1;
        if (PAR) step(1, 0); else step(1, 0);
        dout_ready = 0;
        check("t4_dout", dout, 4'b0110);
        check("t4_valid", dout_valid, 1);
        check("t4_ovr", overrun, 0);
        consume();
        check("t4_consumed", dout_valid, 0);

        // Test 5: async reset mid-frame
        step(1, 1); step(1, 1);
        #2 rst = 1;
        #1;
        check("t5_dout", dout, 0);
        check("t5_cnt", bit_cnt, 0);
        check("t5_busy", busy, 0);
        rst = 0;
        direction = 1;
        send4(4'b0110);
        check("t5_word", dout, 4'b0110);
        check("t5_valid", dout_valid, 1);
        consume();

`ifdef PARITY_CHECK_EN
        // Test 6: even parity good and bad
        for (int i = 3; i >= 0; i--) step(1, 1'(4'b1011 >> i));
        check("t6_cnt_par", bit_cnt, 4);
        step(1, 1);
        check("t6_dout_ok", dout, 4'b1011);
        check("t6_perr_ok", parity_err, 0);
        consume();
        for (int i = 3; i >= 0; i--) step(1, 1'(4'b1011 >> i));
        step(1, 0);
        check("t6_dout_bad", dout, 4'b1011);
        check("t6_perr_bad", parity_err, 1);
        consume();
`else
        check("t6_perr_tied", parity_err, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
